// File: rtl/sprite_mem_pkg.sv
// Shared types and constants for the sprite memory arbiter.
// Requester indices double as bit positions in req/lock/we/gnt/rvalid.
package sprite_mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 64;
   localparam int NREQ       = 3;

   localparam int REQ_MOVE = 0;
   localparam int REQ_COLL = 1;
   localparam int REQ_CPU  = 2;

   typedef enum logic {IDLE, OWN} state_e;

   function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
      logic [1:0] idx;
      idx = 2'(REQ_MOVE);
      if (oh[REQ_COLL]) idx = 2'(REQ_COLL);
      if (oh[REQ_CPU])  idx = 2'(REQ_CPU);
      return idx;
   endfunction

endpackage

// File: rtl/sprite_mem_arbiter_if.sv
// Requester and memory-side bundle of the sprite memory arbiter.
// slave = arbiter view; master = requesters plus the RAM model driving mem_rdata.
interface sprite_mem_arbiter_if
   import sprite_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        lock;
   logic [NREQ-1:0]        we;
   logic [NREQ*ADDR_W-1:0] addr;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;
   logic                   lock_expired;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;

   modport slave (
      input  req, lock, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, lock_expired, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, lock, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, lock_expired, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rr_picker.sv
// Combinational 3-way round-robin pick: first set req bit from rr_ptr upward, wrapping.
// Zero latency; no backpressure.
module rr_picker
   import sprite_mem_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      rr_ptr,
   output logic [NREQ-1:0] win_oh,
   output logic            any
);

   logic [1:0] idx;

   always_comb begin
      win_oh = '0;
      idx    = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (win_oh == '0 && req[idx]) win_oh[idx] = 1'b1;
         idx = (idx == 2'(NREQ - 1)) ? 2'd0 : idx + 2'd1;
      end
   end

   assign any = |req;

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter with capped lock for the single-port sprite RAM; grant 1 cycle after req, rvalid 1 cycle after gnt.
// Requesters hold req until granted; a lock keeps ownership for at most LOCK_MAX consecutive cycles.
module sprite_mem_arbiter
   import sprite_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LOCK_MAX = 16
)(
   input logic                 clk,
   input logic                 rst_n,
   sprite_mem_arbiter_if.slave bus
);

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   state_e            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [7:0]        lock_cnt_q, lock_cnt_d;
   logic [NREQ-1:0]   rvalid_q, rvalid_d;
   logic              lock_expired_q, lock_expired_d;
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
   logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

   logic              own_req, own_lock, own_we;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;
   logic              gnt_any, keep, expire, pick_any;
   logic [NREQ-1:0]   gnt, win_oh;
   logic [1:0]        win_idx;

   rr_picker u_picker (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .win_oh (win_oh),
      .any    (pick_any)
   );

   assign win_idx = oh2idx(win_oh);

   always_comb begin
      own_req   = 1'b0;
      own_lock  = 1'b0;
      own_we    = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == 2'(i)) begin
            own_req   = bus.req[i];
            own_lock  = bus.lock[i];
            own_we    = bus.we[i];
            own_addr  = bus.addr[i*ADDR_W +: ADDR_W];
            own_wdata = bus.wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // A granted owner keeps the bus only while it still requests and holds lock under the cap.
   assign gnt_any = (state_q == OWN) && own_req;
   assign gnt     = gnt_any ? (NREQ'(1) << owner_q) : '0;
   assign keep    = gnt_any && own_lock && (lock_cnt_q != LOCK_MAX_C);
   assign expire  = gnt_any && own_lock && (lock_cnt_q == LOCK_MAX_C);

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      rr_ptr_d       = rr_ptr_q;
      lock_cnt_d     = lock_cnt_q;
      if (keep) begin
         lock_cnt_d = lock_cnt_q + 8'd1;
      end else if (pick_any) begin
         state_d    = OWN;
         owner_d    = win_idx;
         rr_ptr_d   = (win_idx == 2'(NREQ - 1)) ? 2'd0 : win_idx + 2'd1;
         lock_cnt_d = 8'd1;
      end else begin
         state_d    = IDLE;
         lock_cnt_d = 8'd0;
      end
      rvalid_d       = gnt & ~bus.we;
      lock_expired_d = expire;
      addr_hold_d    = gnt_any ? own_addr  : addr_hold_q;
      wdata_hold_d   = gnt_any ? own_wdata : wdata_hold_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= 2'd0;
         rr_ptr_q       <= 2'd0;
         lock_cnt_q     <= 8'd0;
         rvalid_q       <= '0;
         lock_expired_q <= 1'b0;
         addr_hold_q    <= '0;
         wdata_hold_q   <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         rr_ptr_q       <= rr_ptr_d;
         lock_cnt_q     <= lock_cnt_d;
         rvalid_q       <= rvalid_d;
         lock_expired_q <= lock_expired_d;
         addr_hold_q    <= addr_hold_d;
         wdata_hold_q   <= wdata_hold_d;
      end
   end

   assign bus.gnt          = gnt;
   assign bus.rvalid       = rvalid_q;
   assign bus.rdata        = bus.mem_rdata;
   assign bus.lock_expired = lock_expired_q;
   assign bus.mem_we       = gnt_any & own_we;
   assign bus.mem_addr     = gnt_any ? own_addr  : addr_hold_q;
   assign bus.mem_wdata    = gnt_any ? own_wdata : wdata_hold_q;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Scenario bench for sprite_mem_arbiter with a behavioural 1-cycle sprite RAM.
// Read results are queued when a grant is expected and popped when rvalid is due.
module tb_sprite_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 64;
   localparam int LM = 4;

   typedef struct {
      logic [2:0]    rv;
      logic [DW-1:0] data;
   } rd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sprite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   sprite_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [DW-1:0] ram    [256];
   logic [DW-1:0] shadow [256];
   rd_t sb[$];
   rd_t ex;
   int  n_cmp = 0;
   int  n_bad = 0;

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   function automatic logic [DW-1:0] pat(int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i * 32'h0101_0101);
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic r, logic l, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
      bus.req[i]             = r;
      bus.lock[i]            = l;
      bus.we[i]              = w;
      bus.addr[i*AW +: AW]   = a;
      bus.wdata[i*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, '0, '0);
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, '0, '0);
      rst_n = 1'b0;
      nxt(); nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL rst_gnt: got %b want 000", bus.gnt); end
      n_cmp++; if (bus.rvalid !== 3'b000) begin n_bad++; $display("FAIL rst_rvalid: got %b want 000", bus.rvalid); end
      n_cmp++; if (bus.lock_expired !== 1'b0) begin n_bad++; $display("FAIL rst_lock_expired: got %b want 0", bus.lock_expired); end
      n_cmp++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin n_bad++; $display("FAIL rst_mem: we=%b addr=%h wdata=%h want all 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      n_cmp++; if (bus.rdata !== pat(0)) begin n_bad++; $display("FAIL rst_rdata: got %h want %h", bus.rdata, pat(0)); end
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      set_req(0, 1, 0, 0, 8'h05, '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL sr_latency: gnt %b want 000", bus.gnt); end
      nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b001 || bus.mem_addr !== 8'h05 || bus.mem_we !== 1'b0) begin
         n_bad++; $display("FAIL sr_grant: gnt=%b addr=%h we=%b want 001 05 0", bus.gnt, bus.mem_addr, bus.mem_we); end
      sb.push_back('{3'b001, shadow[5]});
      nxt();
      set_req(0, 0, 0, 0, 8'h05, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL sr_rdata: rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, ex.rv, ex.data); end
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL sr_release: gnt %b want 000", bus.gnt); end
      nxt();
   endtask

   task automatic test_round_robin();
      logic [2:0] eg;
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 1, 0, 0, 8'(8'h10 + i), '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL rr_latency: gnt %b want 000", bus.gnt); end
      nxt();
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         eg = 3'b001 << (j % 3);
         n_cmp++; if (bus.gnt !== eg || bus.mem_addr !== 8'(8'h10 + j % 3)) begin
            n_bad++; $display("FAIL rr_gnt%0d: gnt=%b addr=%h want %b %h", j, bus.gnt, bus.mem_addr, eg, 8'(8'h10 + j % 3)); end
         if (j > 0) begin
            ex = sb.pop_front();
            n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
               n_bad++; $display("FAIL rr_rd%0d: rvalid=%b rdata=%h want %b %h", j, bus.rvalid, bus.rdata, ex.rv, ex.data); end
         end
         sb.push_back('{eg, shadow[8'h10 + j % 3]});
         nxt();
      end
      for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.gnt !== 3'b000 || bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL rr_tail: gnt=%b rvalid=%b rdata=%h want 000 %b %h", bus.gnt, bus.rvalid, bus.rdata, ex.rv, ex.data); end
      nxt();
   endtask

   task automatic test_rmw();
      set_req(0, 1, 1, 0, 8'h03, '0);
      @(negedge clk);
      nxt();
      set_req(2, 1, 0, 0, 8'h20, '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b001 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h03) begin
         n_bad++; $display("FAIL rmw_read: gnt=%b we=%b addr=%h want 001 0 03", bus.gnt, bus.mem_we, bus.mem_addr); end
      sb.push_back('{3'b001, shadow[3]});
      nxt();
      set_req(0, 1, 0, 1, 8'h03, 64'hC0DE);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b001 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 64'hC0DE) begin
         n_bad++; $display("FAIL rmw_write: gnt=%b we=%b wdata=%h want 001 1 c0de", bus.gnt, bus.mem_we, bus.mem_wdata); end
      ex = sb.pop_front();
      n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL rmw_rd: rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, ex.rv, ex.data); end
      shadow[3] = 64'hC0DE;
      nxt();
      set_req(0, 0, 0, 0, '0, '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b100 || bus.rvalid !== 3'b000) begin
         n_bad++; $display("FAIL rmw_cpu: gnt=%b rvalid=%b want 100 000", bus.gnt, bus.rvalid); end
      sb.push_back('{3'b100, shadow[8'h20]});
      nxt();
      set_req(2, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.gnt !== 3'b000 || bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL rmw_cpu_rd: gnt=%b rvalid=%b rdata=%h want 000 %b %h", bus.gnt, bus.rvalid, bus.rdata, ex.rv, ex.data); end
      n_cmp++; if (ram[3] !== 64'hC0DE) begin n_bad++; $display("FAIL rmw_ram: ram[3]=%h want c0de", ram[3]); end
      nxt();
   endtask

   task automatic test_lock_expire();
      set_req(1, 1, 1, 0, 8'h30, '0);
      set_req(2, 1, 0, 0, 8'h40, '0);
      @(negedge clk);
      nxt();
      for (int j = 0; j < LM; j++) begin
         @(negedge clk);
         n_cmp++; if (bus.gnt !== 3'b010 || bus.lock_expired !== 1'b0) begin
            n_bad++; $display("FAIL le_hold%0d: gnt=%b expired=%b want 010 0", j, bus.gnt, bus.lock_expired); end
         if (j > 0) begin
            ex = sb.pop_front();
            n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
               n_bad++; $display("FAIL le_rd%0d: rvalid=%b rdata=%h want %b %h", j, bus.rvalid, bus.rdata, ex.rv, ex.data); end
         end
         sb.push_back('{3'b010, shadow[8'h30]});
         nxt();
      end
      set_req(1, 0, 0, 0, '0, '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b100 || bus.lock_expired !== 1'b1) begin
         n_bad++; $display("FAIL le_expire: gnt=%b expired=%b want 100 1", bus.gnt, bus.lock_expired); end
      ex = sb.pop_front();
      n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL le_last_rd: rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, ex.rv, ex.data); end
      sb.push_back('{3'b100, shadow[8'h40]});
      nxt();
      set_req(2, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.gnt !== 3'b000 || bus.lock_expired !== 1'b0 || bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL le_cpu_rd: gnt=%b expired=%b rvalid=%b rdata=%h want 000 0 %b %h",
                           bus.gnt, bus.lock_expired, bus.rvalid, bus.rdata, ex.rv, ex.data); end
      nxt();
   endtask

   task automatic test_reset_mid();
      set_req(1, 1, 0, 0, 8'h07, '0);
      @(negedge clk);
      nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL rm_grant: gnt %b want 010", bus.gnt); end
      nxt();
      set_req(1, 0, 0, 0, '0, '0);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rvalid !== 3'b000 || bus.gnt !== 3'b000) begin
         n_bad++; $display("FAIL rm_abort: rvalid=%b gnt=%b want 000 000", bus.rvalid, bus.gnt); end
      nxt();
      rst_n = 1'b1;
      set_req(1, 1, 0, 0, 8'h08, '0);
      set_req(2, 1, 0, 0, 8'h09, '0);
      @(negedge clk);
      n_cmp++; if (bus.rvalid !== 3'b000 || bus.gnt !== 3'b000) begin
         n_bad++; $display("FAIL rm_after: rvalid=%b gnt=%b want 000 000", bus.rvalid, bus.gnt); end
      nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL rm_ptr: gnt %b want 010", bus.gnt); end
      sb.push_back('{3'b010, shadow[8'h08]});
      nxt();
      set_req(1, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.gnt !== 3'b100 || bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL rm_next: gnt=%b rvalid=%b rdata=%h want 100 %b %h", bus.gnt, bus.rvalid, bus.rdata, ex.rv, ex.data); end
      sb.push_back('{3'b100, shadow[8'h09]});
      nxt();
      set_req(2, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL rm_cpu_rd: rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, ex.rv, ex.data); end
      nxt();
   endtask

   task automatic test_drop_locked();
      set_req(0, 1, 1, 1, 8'h50, 64'hFEED_0050);
      @(negedge clk);
      nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b001 || bus.mem_we !== 1'b1) begin
         n_bad++; $display("FAIL dl_write: gnt=%b we=%b want 001 1", bus.gnt, bus.mem_we); end
      shadow[8'h50] = 64'hFEED_0050;
      nxt();
      set_req(0, 0, 1, 1, 8'h50, 64'hFEED_0050);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b000 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h50) begin
         n_bad++; $display("FAIL dl_drop: gnt=%b we=%b addr=%h want 000 0 50", bus.gnt, bus.mem_we, bus.mem_addr); end
      nxt();
      set_req(0, 0, 0, 0, '0, '0);
      set_req(2, 1, 0, 0, 8'h50, '0);
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL dl_idle: gnt %b want 000", bus.gnt); end
      nxt();
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 3'b100) begin n_bad++; $display("FAIL dl_regrant: gnt %b want 100", bus.gnt); end
      sb.push_back('{3'b100, shadow[8'h50]});
      nxt();
      set_req(2, 0, 0, 0, '0, '0);
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++; if (bus.rvalid !== ex.rv || bus.rdata !== ex.data) begin
         n_bad++; $display("FAIL dl_readback: rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, ex.rv, ex.data); end
      nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, still running");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]    = pat(i);
         shadow[i] = pat(i);
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_rmw();
      test_lock_expire();
      test_reset_mid();
      test_drop_locked();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: %0d entries left, want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
